// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// mem_wb_stage : RV32I memory-access / write-back pipeline register
// Rev 1.0
// ============================================================================
module mem_wb_stage #(
   parameter int BUS_WIDTH   = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 ex_valid,
   input  logic [BUS_WIDTH-1:0] ex_alu_result,
   input  logic [BUS_WIDTH-1:0] ex_store_data,
   input  logic [BUS_WIDTH-1:0] ex_pc,
   input  logic [BUS_WIDTH-1:0] ex_csr_rdata,
   input  logic [4:0]           ex_rd,
   input  logic                 ex_reg_wr,
   input  logic [1:0]           ex_wb_sel,
   input  logic                 ex_mem_rd,
   input  logic                 ex_mem_wr,
   input  logic [2:0]           ex_funct3,
   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [BUS_WIDTH-1:0] dmem_addr,
   output logic [BUS_WIDTH-1:0] dmem_wdata,
   output logic [3:0]           dmem_wmask,
   input  logic                 dmem_ack,
   input  logic [BUS_WIDTH-1:0] dmem_rdata,
   output logic                 stall_o,
   output logic [1:0]           wb_sel,
   output logic [BUS_WIDTH-1:0] wb_alu,
   output logic [BUS_WIDTH-1:0] wb_load,
   output logic [BUS_WIDTH-1:0] wb_pc4,
   output logic [BUS_WIDTH-1:0] wb_csr,
   output logic [4:0]           wb_rd,
   output logic                 wb_reg_wr,
   output logic                 misalign_o,
   output logic                 bus_err_o
);

   localparam int                 c_CNT_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT_CYC);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [c_CNT_W-1:0] cnt_q, cnt_d;

   logic [1:0]           wb_sel_q;
   logic [BUS_WIDTH-1:0] wb_alu_q, wb_load_q, wb_pc4_q, wb_csr_q;
   logic [4:0]           wb_rd_q;
   logic                 wb_reg_wr_q;

   logic [1:0]           w_off;
   logic                 w_mem_op;
   logic                 w_misaligned;
   logic                 w_timeout_hit;
   logic                 w_req;
   logic                 w_stall;
   logic [7:0]           w_byte;
   logic [15:0]          w_half;
   logic [BUS_WIDTH-1:0] w_load;
   logic [3:0]           w_mask;
   logic [BUS_WIDTH-1:0] w_wdata;

   assign w_off    = ex_alu_result[1:0];
   assign w_mem_op = ex_valid & ~flush & (ex_mem_rd | ex_mem_wr);

   always_comb begin
      w_misaligned = 1'b0;
      if (w_mem_op) begin
         case (ex_funct3[1:0])
            2'b01:   w_misaligned = w_off[0];
            2'b10:   w_misaligned = (w_off != 2'b00);
            default: w_misaligned = 1'b0;
         endcase
      end
   end

   assign w_timeout_hit = (state_q == S_WAIT) && (cnt_q == c_TIMEOUT);
   assign w_req         = w_mem_op & ~w_misaligned & ~w_timeout_hit;
   assign w_stall       = w_req & ~dmem_ack;

   assign dmem_req   = w_req;
   assign dmem_we    = w_req & ex_mem_wr;
   assign dmem_addr  = {ex_alu_result[BUS_WIDTH-1:2], 2'b00};
   assign dmem_wdata = w_wdata;
   assign dmem_wmask = (w_req & ex_mem_wr) ? w_mask : 4'b0000;
   assign stall_o    = w_stall;
   assign misalign_o = w_misaligned;
   assign bus_err_o  = w_timeout_hit;

   // Load lane extraction and sign/zero extension
   always_comb begin
      case (w_off)
         2'd0:    w_byte = dmem_rdata[7:0];
         2'd1:    w_byte = dmem_rdata[15:8];
         2'd2:    w_byte = dmem_rdata[23:16];
         default: w_byte = dmem_rdata[31:24];
      endcase
      w_half = w_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (ex_funct3)
         3'b000:  w_load = {{(BUS_WIDTH-8){w_byte[7]}}, w_byte};
         3'b001:  w_load = {{(BUS_WIDTH-16){w_half[15]}}, w_half};
         3'b100:  w_load = {{(BUS_WIDTH-8){1'b0}}, w_byte};
         3'b101:  w_load = {{(BUS_WIDTH-16){1'b0}}, w_half};
         default: w_load = dmem_rdata;
      endcase
   end

   always_comb begin
      case (ex_funct3[1:0])
         2'b00: begin
            w_mask  = 4'b0001 << w_off;
            w_wdata = {4{ex_store_data[7:0]}};
         end
         2'b01: begin
            w_mask  = 4'b0011 << w_off;
            w_wdata = {2{ex_store_data[15:0]}};
         end
         default: begin
            w_mask  = 4'b1111;
            w_wdata = ex_store_data;
         end
      endcase
   end

   // A dropped request (flush or timeout) also returns WAIT to IDLE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (w_req & ~dmem_ack) begin
               state_d = S_WAIT;
               cnt_d   = c_CNT_W'(1);
            end
         end
         S_WAIT: begin
            if (~w_req | dmem_ack) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + c_CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_sel_q    <= 2'b00;
         wb_alu_q    <= '0;
         wb_load_q   <= '0;
         wb_pc4_q    <= '0;
         wb_csr_q    <= '0;
         wb_rd_q     <= 5'd0;
         wb_reg_wr_q <= 1'b0;
      end else if (!w_stall) begin
         wb_sel_q    <= ex_wb_sel;
         wb_alu_q    <= ex_alu_result;
         wb_load_q   <= w_load;
         wb_pc4_q    <= ex_pc + BUS_WIDTH'(4);
         wb_csr_q    <= ex_csr_rdata;
         wb_rd_q     <= ex_rd;
         wb_reg_wr_q <= ex_valid & ~flush & ex_reg_wr & ~w_misaligned & ~w_timeout_hit;
      end
   end

   assign wb_sel    = wb_sel_q;
   assign wb_alu    = wb_alu_q;
   assign wb_load   = wb_load_q;
   assign wb_pc4    = wb_pc4_q;
   assign wb_csr    = wb_csr_q;
   assign wb_rd     = wb_rd_q;
   assign wb_reg_wr = wb_reg_wr_q;

endmodule
`default_nettype wire
